// File: rtl/solution_serializer.sv
// Latches a solved grid and streams it to uart_tx as a header byte {n,m} followed by row bitmap bytes.
// Latency: first strobe 1 cycle after valid_in, then 1 cycle after each transmit_done; one byte outstanding.
module solution_serializer #(
    parameter int MAX_N = 11,
    parameter int MAX_M = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [MAX_N*MAX_M-1:0] solution,
    input  logic [3:0]             n,
    input  logic [3:0]             m,
    input  logic                   transmit_done,
    output logic                   transmit_ready,
    output logic [7:0]             byte_out,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int G = MAX_N * MAX_M;

    typedef enum logic [2:0] {IDLE, HEADER, ROW_LO, ROW_HI, WAIT, FINISH} state_t;

    state_t       state;
    state_t       sent;
    logic [G-1:0] grid;
    logic [3:0]   n_eff;
    logic [3:0]   m_eff;
    logic [3:0]   row;

    logic [3:0]   n_clamp;
    logic [3:0]   m_clamp;
    logic         wide;
    logic         last_row;
    logic         last_byte;
    logic [3:0]   tgt_row;
    logic [G-1:0] shifted;
    logic [15:0]  col_mask;
    logic [15:0]  row_word;

    always_comb begin
        n_clamp  = (n > 4'(MAX_N)) ? 4'(MAX_N) : n;
        m_clamp  = (m > 4'(MAX_M)) ? 4'(MAX_M) : m;
        wide     = m_eff > 4'd8;
        last_row = row == (n_eff - 4'd1);
        // Header of an empty grid ends the frame; otherwise the row's final byte does.
        if (sent == HEADER) begin
            last_byte = (n_eff == 4'd0) || (m_eff == 4'd0);
        end else begin
            last_byte = ((sent == ROW_HI) || !wide) && last_row;
        end
        if (sent == HEADER) begin
            tgt_row = 4'd0;
        end else if (sent == ROW_LO && wide) begin
            tgt_row = row;
        end else begin
            tgt_row = row + 4'd1;
        end
        shifted  = grid >> (32'(tgt_row) * MAX_M);
        col_mask = (16'd1 << m_eff) - 16'd1;
        row_word = '0;
        row_word[MAX_M-1:0] = shifted[MAX_M-1:0];
        row_word = row_word & col_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sent           <= IDLE;
            grid           <= '0;
            n_eff          <= '0;
            m_eff          <= '0;
            row            <= '0;
            transmit_ready <= 1'b0;
            byte_out       <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            transmit_ready <= 1'b0;
            frame_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        grid           <= solution;
                        n_eff          <= n_clamp;
                        m_eff          <= m_clamp;
                        row            <= '0;
                        busy           <= 1'b1;
                        byte_out       <= {n_clamp, m_clamp};
                        transmit_ready <= 1'b1;
                        state          <= HEADER;
                    end
                end
                HEADER, ROW_LO, ROW_HI: begin
                    sent  <= state;
                    state <= WAIT;
                end
                WAIT: begin
                    if (transmit_done) begin
                        if (last_byte) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            row            <= tgt_row;
                            transmit_ready <= 1'b1;
                            if (sent == ROW_LO && wide) begin
                                byte_out <= row_word[15:8];
                                state    <= ROW_HI;
                            end else begin
                                byte_out <= row_word[7:0];
                                state    <= ROW_LO;
                            end
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_solution_serializer.sv
// Directed + randomized frames checked against a cell-level model of the byte framing.
module tb_solution_serializer;
    localparam int MN = 11;
    localparam int MM = 11;
    localparam int G  = MN * MM;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic [G-1:0] solution = '0;
    logic [3:0]   n = '0;
    logic [3:0]   m = '0;
    logic         transmit_done = 1'b0;
    logic         transmit_ready;
    logic [7:0]   byte_out;
    logic         busy;
    logic         frame_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    solution_serializer #(.MAX_N(MN), .MAX_M(MM)) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .solution(solution),
        .n(n),
        .m(m),
        .transmit_done(transmit_done),
        .transmit_ready(transmit_ready),
        .byte_out(byte_out),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [G-1:0] rand_grid();
        logic [G-1:0] g;
        for (int i = 0; i < G; i++) g[i] = 1'($urandom_range(0, 1));
        return g;
    endfunction

    // Expected stream: header, then per row a low byte (cols 0..7) and, for wide grids, a high byte.
    task automatic build_exp(input logic [G-1:0] g, input int nn, input int mm);
        int ne;
        int me;
        logic [15:0] w;
        ne = (nn > MN) ? MN : nn;
        me = (mm > MM) ? MM : mm;
        exp_q.delete();
        exp_q.push_back(8'((ne << 4) | me));
        if (ne > 0 && me > 0) begin
            for (int r = 0; r < ne; r++) begin
                w = '0;
                for (int c = 0; c < me; c++) w[c] = g[r * MM + c];
                exp_q.push_back(w[7:0]);
                if (me > 8) exp_q.push_back(w[15:8]);
            end
        end
    endtask

    task automatic run_frame(input logic [G-1:0] g, input logic [3:0] nn, input logic [3:0] mm,
                             input int fixed_dly, input bit poke, input int abort_at);
        int dly;
        build_exp(g, int'(nn), int'(mm));
        solution = g;
        n = nn;
        m = mm;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        solution = rand_grid();
        n = 4'($urandom);
        m = 4'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("strobe", 32'(transmit_ready), 1);
            chk("byte", 32'(byte_out), 32'(exp_q[i]));
            chk("busy_in_frame", 32'(busy), 1);
            dly = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 6);
            for (int k = 0; k < dly; k++) begin
                @(posedge clk); #1;
                if (poke && k == 0) begin
                    valid_in = 1'b1;
                    solution = ~g;
                    n = 4'd3;
                    m = 4'd3;
                end else begin
                    valid_in = 1'b0;
                end
                chk("quiet_wait", 32'(transmit_ready), 0);
                chk("byte_hold", 32'(byte_out), 32'(exp_q[i]));
                chk("no_early_done", 32'(frame_done), 0);
            end
            if (i == abort_at) begin
                valid_in = 1'b0;
                #3 rst = 1'b1;
                #1;
                chk("abort_ready", 32'(transmit_ready), 0);
                chk("abort_byte", 32'(byte_out), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(frame_done), 0);
                #1 rst = 1'b0;
                @(posedge clk); #1;
                transmit_done = 1'b1;
                @(posedge clk); #1;
                transmit_done = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #1;
                    chk("abort_no_strobe", 32'(transmit_ready), 0);
                    chk("abort_idle", 32'(busy), 0);
                end
                return;
            end
            transmit_done = 1'b1;
            valid_in = 1'b0;
            @(posedge clk); #1;
            transmit_done = 1'b0;
        end
        chk("frame_done", 32'(frame_done), 1);
        chk("busy_end", 32'(busy), 0);
        chk("no_strobe_end", 32'(transmit_ready), 0);
        valid_in = 1'b1;
        solution = rand_grid();
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("frame_done_pulse", 32'(frame_done), 0);
        chk("finish_valid_ignored", 32'(transmit_ready), 0);
        chk("finish_busy", 32'(busy), 0);
    endtask

    initial begin
        logic [G-1:0] g;
        logic [G-1:0] g2;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(transmit_ready), 0);
        chk("reset_byte", 32'(byte_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(frame_done), 0);
        rst = 1'b0;

        // Stray transmit_done in IDLE must not produce a strobe.
        @(posedge clk); #1;
        transmit_done = 1'b1;
        @(posedge clk); #1;
        transmit_done = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_stray_done", 32'(transmit_ready), 0);
        end

        g = '0;
        for (int r = 0; r < MN; r++) g[r * MM + r] = 1'b1;
        run_frame(g, 4'd11, 4'd11, 20, 1'b0, -1);
        chk("diag_len", exp_q.size(), 23);

        g = rand_grid();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) g[r * MM + c] = 1'b1;
        run_frame(g, 4'd5, 4'd5, 0, 1'b0, -1);
        chk("ones_len", exp_q.size(), 6);

        g = rand_grid();
        g2 = ~g;
        run_frame(g, 4'd11, 4'd10, 0, 1'b1, -1);
        run_frame(g2, 4'd3, 4'd3, 0, 1'b0, -1);

        run_frame(rand_grid(), 4'd0, 4'd7, 0, 1'b0, -1);
        run_frame(rand_grid(), 4'd6, 4'd0, 0, 1'b0, -1);
        run_frame(rand_grid(), 4'd15, 4'd15, 0, 1'b0, -1);
        chk("clamp_len", exp_q.size(), 23);

        // Abort while waiting on row 3's low byte (index 7 of an 11x11 frame).
        run_frame(rand_grid(), 4'd11, 4'd11, 3, 1'b0, 7);
        run_frame(rand_grid(), 4'd11, 4'd11, 0, 1'b0, -1);

        for (int t = 0; t < 20; t++) begin
            run_frame(rand_grid(), 4'($urandom), 4'($urandom), 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/solution_serializer.md
Name: solution_serializer

Overview:
- Transmit-side counterpart of the board parser: latches a solved nonogram grid and emits it as a byte stream to the UART transmitter, one byte per transmitter completion.
- Sits between the solver output and uart_tx in the top level; output byte framing mirrors the parser's input framing (dimension header, then row bitmaps).

Parameters:
MAX_N, 11, maximum row count supported
MAX_M, 11, maximum column count supported (≤16)

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous reset, active-high
valid_in  input  1  one-cycle pulse; solution/n/m are valid, start serializing
solution  input  MAX_N*MAX_M  grid; bit r*MAX_M+c = cell (row r, col c), 1 = filled
n  input  4  row count
m  input  4  column count
transmit_done  input  1  one-cycle pulse from uart_tx when the current byte has been fully shifted out
transmit_ready  output  1  one-cycle strobe; byte_out valid for uart_tx
byte_out  output  8  byte to transmit
busy  output  1  high from accepted valid_in until frame complete
frame_done  output  1  one-cycle pulse after the last byte's transmit_done

Behaviour:
- Reset (async, rst=1): state IDLE; transmit_ready=0, byte_out=0, busy=0, frame_done=0; latched grid and counters cleared. rst asserted mid-frame aborts immediately; no further strobes until a new valid_in.
- Latching: in IDLE, valid_in=1 captures solution, n, m into internal registers; the next cycle busy=1. Inputs may change afterwards. valid_in while busy is ignored (no restart, no re-latch).
- Clamping: n_eff = min(n, MAX_N), m_eff = min(m, MAX_M); header carries the clamped values.
- Frame format: byte 0 = {n_eff[3:0], m_eff[3:0]}; then for r = 0..n_eff-1: low byte = cells c=0..7 of row r (bit i = col i); if m_eff > 8, high byte = cols 8..m_eff-1 in bits 0..(m_eff-9); unused bits always 0. Total bytes = 1 + n_eff*(m_eff>8 ? 2 : 1).
- States: IDLE -> HEADER (cycle after valid_in) -> WAIT -> ROW_LO -> WAIT -> [ROW_HI -> WAIT] -> ... -> FINISH -> IDLE.
  - HEADER/ROW_LO/ROW_HI: drive byte_out, pulse transmit_ready for exactly one cycle, go to WAIT.
  - WAIT: hold byte_out stable; on transmit_done, advance: after header -> ROW_LO r=0 (or FINISH if n_eff=0 or m_eff=0); after ROW_LO -> ROW_HI if m_eff>8 else next row; after last byte of row n_eff-1 -> FINISH.
  - FINISH: frame_done=1 for one cycle, busy=0 the same cycle, return to IDLE.
- Latency: first transmit_ready exactly 1 cycle after valid_in; each subsequent transmit_ready exactly 1 cycle after the transmit_done that completes the previous byte.
- transmit_done outside WAIT is ignored. Never more than one outstanding byte.
- Row counter 4 bits, no wrap: terminates at n_eff-1. Degenerate n_eff=0 or m_eff=0: header only, then frame_done.
- valid_in in the same cycle as frame_done (FINISH): ignored; accepted from the following IDLE cycle.

Test Plan:
- Reset values: assert rst asynchronously between clock edges -> all outputs 0 immediately, state IDLE.
- 11x11 diagonal grid (cell r,r=1), transmit_done returned 20 cycles after each strobe -> 23 bytes: 0xBB, then row0 0x01,0x00 ... row7 0x80,0x00, row8 0x00,0x01, row9 0x00,0x02, row10 0x00,0x04; frame_done once after 23rd transmit_done; busy high throughout.
- 5x5 all-ones grid -> 6 bytes: 0x55, then 0x1F x5; no high bytes; bits 5..7 zero even with garbage bits set in solution beyond col 4.
- valid_in pulsed again mid-frame with different grid -> stream unchanged, exactly one frame_done; a second valid_in after frame_done starts a new frame with the new data.
- n=0, m=7 -> single byte 0x07, then frame_done; n=15, m=15 -> header 0xBB, 23 bytes (clamped).
- rst pulsed during WAIT of row 3 -> outputs 0, no further transmit_ready; stray transmit_done afterwards produces no strobe; fresh valid_in restarts from header.
